cofre_controlador: RTL and testbench
====================================

# cofre_controlador

Parametrised, clocked successor to the combinational safe comparator. It holds a programmable password and accepts strobed attempts. It drives the open, near-miss and wrong LEDs as registered outputs. It counts consecutive failures, enforces a timed lockout and shows the remaining attempts on a 7-segment display. It sits between the debounced user inputs (switches and buttons) and the board LEDs and display.

## Interface
Parameters:
- WIDTH, 4: bit width of the password and the attempt.
- TOLERANCIA, 3: maximum absolute difference that counts as a near miss. Range 1..2^WIDTH-1.
- MAX_TENTATIVAS, 3: consecutive wrong attempts that trigger lockout. Range 1..9.
- BLOQUEIO_CICLOS, 16: lockout duration in clock cycles. Must be ≥1.
- SENHA_INICIAL, 0: password loaded at reset.

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- rst_n, input, 1: one clock; reset is synchronous and active-low.
- tentativa, input, WIDTH: user attempt. Also the new-password source when programming.
- confirmar, input, 1: single-cycle strobe. Each high cycle is one attempt.
- fechar, input, 1: single-cycle strobe that closes an open safe.
- programar, input, 1: single-cycle strobe. Only while open, it loads tentativa as the new password.
- led0, output, 1: safe open.
- led1, output, 1: last attempt was wrong but within TOLERANCIA.
- led2, output, 1: last attempt was wrong.
- led_bloqueio, output, 1: lockout active.
- display, output, 8: [6:0] segments a..g, active-high; [7] decimal point = lockout.

## Operation
- States: FECHADO, ABERTO, BLOQUEADO.
- Reset values: state FECHADO; senha = SENHA_INICIAL; failure counter 0; led0/led1/led2/led_bloqueio = 0; display = digit MAX_TENTATIVAS with dp = 0.
- FECHADO, on confirmar:
  - tentativa == senha: go to ABERTO; counter cleared; led1 = led2 = 0.
  - Otherwise: led2 = 1; led1 = (diff ≤ TOLERANCIA); counter increments.
  - If the counter reaches MAX_TENTATIVAS: go to BLOQUEADO, load the lockout timer, clear the counter.
- ABERTO:
  - confirmar is ignored.
  - programar: senha ← tentativa.
  - fechar: go to FECHADO; led1 = led2 = 0.
  - programar and fechar in the same cycle: both take effect (new password, state FECHADO).
- BLOQUEADO:
  - confirmar, fechar and programar are all ignored.
  - The timer decrements each cycle. When it expires: go to FECHADO; led1 = led2 = 0.
- Arithmetic:
  - diff = |senha − tentativa|, computed in WIDTH+1 bits from the sign of the borrow. No wrap-around: senha = 0, tentativa = 2^WIDTH−1 gives the full difference.
  - The TOLERANCIA compare is unsigned.
- Display:
  - Shows MAX_TENTATIVAS − counter as a decimal digit.
  - Shows 0 during BLOQUEADO, with dp = 1.
  - Shows the "A" glyph while ABERTO.
- led1/led2 hold their value until the next evaluated attempt or a state change.

## Timing
- All outputs are registered. An event sampled at edge n is visible after edge n, i.e. during cycle n+1.
- Lockout window: if the MAX_TENTATIVAS-th wrong confirmar is sampled at edge n, led_bloqueio is high for exactly BLOQUEIO_CICLOS cycles starting at n+1. FECHADO is entered on the following edge.
- Back-to-back confirmar on consecutive cycles: each strobe is a separate attempt.
- rst_n low at any edge, including mid-lockout or while open, restores all reset values at that edge. Reset has priority over every other input.

## Structure
- Package cofre_pkg:
  - State enum (FECHADO, ABERTO, BLOQUEADO).
  - 7-segment constants for digits 0–9 and the "A" glyph.
  - Digit-to-segment function.
- Sub-module diferenca_abs (parametrised by WIDTH): combinational subtract with borrow, producing the absolute difference. Instantiated once.
- Everything else lives in one FSM/counter module.

## Test plan
- Reset, then confirmar with tentativa = 0 (defaults): led0 = 1 next cycle, display = "A".
- In FECHADO with senha = 5, confirmar with tentativa = 7: led1 = led2 = 1, display = 2. Then confirmar with tentativa = 12: led1 = 0, led2 = 1, display = 1.
- Three wrong attempts, then confirmar with the correct password during lockout: led_bloqueio high for exactly 16 cycles, the correct attempt is ignored, state returns to FECHADO, display = 3.
- While open: programar with tentativa = 9, then fechar. Confirmar 0 → led2 = 1. Confirmar 9 → led0 = 1.
- Boundary: senha = 0, tentativa = 15 → led1 = 0. senha = 15, tentativa = 12 → led1 = 1.
- rst_n low in the middle of a lockout: led_bloqueio = 0 and display = 3 next cycle, and senha is restored to 0.

Source files
------------

// File: rtl/cofre_pkg.sv
// Shared types and 7-segment encodings for the safe controller.
// Segment bit 0 is 'a' through bit 6 is 'g', active-high.
package cofre_pkg;

  typedef enum logic [1:0] {
    FECHADO   = 2'd0,
    ABERTO    = 2'd1,
    BLOQUEADO = 2'd2
  } cofre_estado_t;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;

  function automatic logic [6:0] digito_7seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/diferenca_abs.sv
// Absolute difference |a - b| taken from the borrow of a WIDTH+1-bit subtract,
// so the full range is representable with no wrap-around.
module diferenca_abs #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o
);

  logic [WIDTH:0] sub_ab;
  logic [WIDTH:0] sub_ba;

  assign sub_ab = {1'b0, a_i} - {1'b0, b_i};
  assign sub_ba = {1'b0, b_i} - {1'b0, a_i};

  // A set top bit is the borrow: a < b, so take the reverse subtraction.
  assign diff_o = sub_ab[WIDTH] ? sub_ba[WIDTH-1:0] : sub_ab[WIDTH-1:0];

endmodule

// File: rtl/cofre_controlador.sv
// Clocked safe controller: password compare, failure counting, timed lockout,
// password programming while open, and a remaining-attempts 7-segment display.
module cofre_controlador
  import cofre_pkg::*;
#(
  parameter int             WIDTH           = 4,
  parameter int             TOLERANCIA      = 3,
  parameter int             MAX_TENTATIVAS  = 3,
  parameter int             BLOQUEIO_CICLOS = 16,
  parameter logic [WIDTH-1:0] SENHA_INICIAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tentativa,
  input  logic             confirmar,
  input  logic             fechar,
  input  logic             programar,
  output logic             led0,
  output logic             led1,
  output logic             led2,
  output logic             led_bloqueio,
  output logic [7:0]       display,
  output logic [1:0]       estado_dbg
);

  localparam int TW = $clog2(BLOQUEIO_CICLOS + 1);
  localparam logic [3:0]    MAX_T = 4'(MAX_TENTATIVAS);
  localparam logic [WIDTH:0] TOL  = (WIDTH + 1)'(TOLERANCIA);

  // confirmar/fechar/programar are single-cycle strobes with no back-pressure:
  // every high cycle sampled at a rising edge is one event.
  cofre_estado_t    estado_q;
  logic [WIDTH-1:0] senha_q;
  logic [3:0]       falhas_q;
  logic [TW-1:0]    timer_q;
  logic             led0_q, led1_q, led2_q, led_bloq_q;
  logic [7:0]       display_q;

  logic [WIDTH-1:0] diff;
  logic             acerto;
  logic             perto;
  logic [3:0]       falhas_d;

  diferenca_abs #(.WIDTH(WIDTH)) u_diff (
    .a_i    (senha_q),
    .b_i    (tentativa),
    .diff_o (diff)
  );

  assign acerto   = (tentativa == senha_q);
  assign perto    = ({1'b0, diff} <= TOL);
  assign falhas_d = falhas_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q   <= FECHADO;
      senha_q    <= SENHA_INICIAL;
      falhas_q   <= '0;
      timer_q    <= '0;
      led0_q     <= 1'b0;
      led1_q     <= 1'b0;
      led2_q     <= 1'b0;
      led_bloq_q <= 1'b0;
      display_q  <= {1'b0, digito_7seg(MAX_T)};
    end else begin
      case (estado_q)
        FECHADO: begin
          if (confirmar) begin
            if (acerto) begin
              estado_q  <= ABERTO;
              falhas_q  <= '0;
              led0_q    <= 1'b1;
              led1_q    <= 1'b0;
              led2_q    <= 1'b0;
              display_q <= {1'b0, SEG_A};
            end else begin
              led1_q <= perto;
              led2_q <= 1'b1;
              if (falhas_d == MAX_T) begin
                estado_q   <= BLOQUEADO;
                falhas_q   <= '0;
                timer_q    <= TW'(BLOQUEIO_CICLOS - 1);
                led_bloq_q <= 1'b1;
                display_q  <= {1'b1, SEG_0};
              end else begin
                falhas_q  <= falhas_d;
                display_q <= {1'b0, digito_7seg(MAX_T - falhas_d)};
              end
            end
          end
        end
        ABERTO: begin
          if (programar) begin
            senha_q <= tentativa;
          end
          if (fechar) begin
            estado_q  <= FECHADO;
            led0_q    <= 1'b0;
            led1_q    <= 1'b0;
            led2_q    <= 1'b0;
            display_q <= {1'b0, digito_7seg(MAX_T - falhas_q)};
          end
        end
        BLOQUEADO: begin
          // Timer holds cycles left after this one; zero means this is the last.
          if (timer_q == '0) begin
            estado_q   <= FECHADO;
            led1_q     <= 1'b0;
            led2_q     <= 1'b0;
            led_bloq_q <= 1'b0;
            display_q  <= {1'b0, digito_7seg(MAX_T - falhas_q)};
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          estado_q <= FECHADO;
        end
      endcase
    end
  end

  assign led0         = led0_q;
  assign led1         = led1_q;
  assign led2         = led2_q;
  assign led_bloqueio = led_bloq_q;
  assign display      = display_q;
  assign estado_dbg   = estado_q;

endmodule

// File: tb/tb_cofre_controlador.sv
// Directed bench for cofre_controlador with default parameters; expected values
// are hand-computed constants for each step.
module tb_cofre_controlador;

  localparam logic [7:0] D_3    = 8'h4F;
  localparam logic [7:0] D_2    = 8'h5B;
  localparam logic [7:0] D_1    = 8'h06;
  localparam logic [7:0] D_A    = 8'h77;
  localparam logic [7:0] D_LOCK = 8'hBF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tentativa;
  logic       confirmar, fechar, programar;
  logic       led0, led1, led2, led_bloqueio;
  logic [7:0] display;
  logic [1:0] estado_dbg;

  int n_vec = 0;
  int n_err = 0;

  cofre_controlador dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tentativa    (tentativa),
    .confirmar    (confirmar),
    .fechar       (fechar),
    .programar    (programar),
    .led0         (led0),
    .led1         (led1),
    .led2         (led2),
    .led_bloqueio (led_bloqueio),
    .display      (display),
    .estado_dbg   (estado_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: set at a falling edge, sampled at the next rising edge,
  // cleared at the following falling edge where outputs are then checked
  task automatic pulse(input logic c, input logic f, input logic p, input logic [3:0] t);
    @(negedge clk);
    tentativa = t; confirmar = c; fechar = f; programar = p;
    @(negedge clk);
    confirmar = 1'b0; fechar = 1'b0; programar = 1'b0;
  endtask

  task automatic tentar(input logic [3:0] t);
    pulse(1'b1, 1'b0, 1'b0, t);
  endtask

  task automatic chk_leds(input string tag, input logic l0, input logic l1, input logic l2,
                          input logic lb, input logic [7:0] disp);
    chk({tag, "_led0"}, 32'(led0), 32'(l0));
    chk({tag, "_led1"}, 32'(led1), 32'(l1));
    chk({tag, "_led2"}, 32'(led2), 32'(l2));
    chk({tag, "_lock"}, 32'(led_bloqueio), 32'(lb));
    chk({tag, "_disp"}, 32'(display), 32'(disp));
  endtask

  initial begin
    int cnt;
    logic abriu;
    rst_n = 1'b0; tentativa = '0; confirmar = 1'b0; fechar = 1'b0; programar = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_leds("reset", 1'b0, 1'b0, 1'b0, 1'b0, D_3);
    rst_n = 1'b1;

    // default password 0 opens
    tentar(4'd0);
    chk_leds("open_default", 1'b1, 1'b0, 1'b0, 1'b0, D_A);

    // programar and fechar together: senha = 5, closed
    pulse(1'b0, 1'b1, 1'b1, 4'd5);
    chk_leds("prog_close", 1'b0, 1'b0, 1'b0, 1'b0, D_3);

    tentar(4'd7);
    chk_leds("near_7", 1'b0, 1'b1, 1'b1, 1'b0, D_2);
    tentar(4'd12);
    chk_leds("far_12", 1'b0, 1'b0, 1'b1, 1'b0, D_1);

    // third wrong attempt enters lockout
    tentar(4'd4);
    chk_leds("lock_enter", 1'b0, 1'b1, 1'b1, 1'b1, D_LOCK);
    tentativa = 4'd5; confirmar = 1'b1;
    cnt = 1;
    abriu = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      confirmar = 1'b0;
      if (led0) abriu = 1'b1;
      if (led_bloqueio) cnt++;
      else break;
    end
    chk("lock_len", 32'(cnt), 32'd16);
    chk("lock_ignored_open", 32'(abriu), 32'd0);
    chk_leds("lock_exit", 1'b0, 1'b0, 1'b0, 1'b0, D_3);

    // open with 5, program 9, confirm ignored while open, close
    tentar(4'd5);
    chk_leds("open_5", 1'b1, 1'b0, 1'b0, 1'b0, D_A);
    pulse(1'b0, 1'b0, 1'b1, 4'd9);
    tentar(4'd3);
    chk_leds("open_ignore", 1'b1, 1'b0, 1'b0, 1'b0, D_A);
    pulse(1'b0, 1'b1, 1'b0, 4'd0);
    chk_leds("closed", 1'b0, 1'b0, 1'b0, 1'b0, D_3);
    tentar(4'd0);
    chk_leds("old_pw", 1'b0, 1'b0, 1'b1, 1'b0, D_2);
    tentar(4'd9);
    chk_leds("new_pw", 1'b1, 1'b0, 1'b0, 1'b0, D_A);

    // boundary: senha 0 vs 15, senha 15 vs 12 and 11
    pulse(1'b0, 1'b1, 1'b1, 4'd0);
    tentar(4'd15);
    chk_leds("bnd_0_15", 1'b0, 1'b0, 1'b1, 1'b0, D_2);
    tentar(4'd0);
    chk_leds("open_0", 1'b1, 1'b0, 1'b0, 1'b0, D_A);
    pulse(1'b0, 1'b1, 1'b1, 4'd15);
    tentar(4'd12);
    chk_leds("bnd_15_12", 1'b0, 1'b1, 1'b1, 1'b0, D_2);
    tentar(4'd11);
    chk_leds("bnd_15_11", 1'b0, 1'b0, 1'b1, 1'b0, D_1);

    // reset restores password 0
    pulse(1'b0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_leds("reset2", 1'b0, 1'b0, 1'b0, 1'b0, D_3);

    // back-to-back strobes are separate attempts
    @(negedge clk);
    tentativa = 4'd1; confirmar = 1'b1;
    @(negedge clk);
    tentativa = 4'd2;
    @(negedge clk);
    confirmar = 1'b0;
    chk_leds("b2b", 1'b0, 1'b1, 1'b1, 1'b0, D_1);
    tentar(4'd8);
    chk_leds("lock2", 1'b0, 1'b0, 1'b1, 1'b1, D_LOCK);

    // reset in the middle of the lockout
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_leds("rst_mid_lock", 1'b0, 1'b0, 1'b0, 1'b0, D_3);
    tentar(4'd0);
    chk_leds("pw_restored", 1'b1, 1'b0, 1'b0, 1'b0, D_A);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
